sync_pkt_fifo: RTL and testbench
================================

// Module: sync_pkt_fifo
// PURPOSE
//  Single-clock FIFO for packet streams: packet commit/drop, FWFT or STD read, programmable almost flags,
//  packet count and sticky error flags. Sits between packet producers and framers so that a half-written
//  or errored packet is never visible to the reader.
// PARAMETERS
//  DATA_WIDTH  8       payload bits per word
//  DEPTH       16      words of storage, power of 2, >=4
//  MODE        "FWFT"  "FWFT": head word shown when valid=1; "STD": dout registered 1 cycle after rd_en
//  PKT_MODE    1       1: writes become readable only at wr_last; 0: every write commits at once
//  AFULL_TH    DEPTH-2 almost_full when wr_data_count >= AFULL_TH
//  AEMPTY_TH   2       almost_empty when rd_data_count <= AEMPTY_TH
// PORTS  (AW = $clog2(DEPTH))
//  sys_clk        in   1           clock, all logic on rising edge
//  rst            in   1           asynchronous active-low reset
//  wr_en          in   1           write request
//  din            in   DATA_WIDTH  write data
//  wr_last        in   1           din is final word of packet
//  wr_drop        in   1           discard the open (uncommitted) packet
//  rd_en          in   1           read request / pop
//  err_clr        in   1           clears overflow and underflow
//  valid          out  1           dout holds a read word
//  dout           out  DATA_WIDTH  read data
//  dout_last      out  1           stored wr_last of dout
//  full/empty     out  1           storage full (incl. uncommitted) / no committed word readable
//  almost_full    out  1           see AFULL_TH
//  almost_empty   out  1           see AEMPTY_TH
//  wr_data_count  out  AW+1        wr_ptr - rd_ptr (committed + uncommitted)
//  rd_data_count  out  AW+1        cmt_ptr - rd_ptr (committed, not yet popped)
//  pkt_count      out  AW+1        complete committed packets not fully popped
//  overflow       out  1           sticky: write attempted while full
//  underflow      out  1           sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async, rst=0): wr_ptr=cmt_ptr=rd_ptr=0, valid=0, dout=0, dout_last=0, full=0, empty=1,
//    almost_full=0, almost_empty=1, counts=0, overflow=underflow=0. Memory contents not reset.
//  - Pointers AW+1 bits, wrap naturally; full = (wr_ptr-rd_ptr)==DEPTH; empty = cmt_ptr==rd_ptr.
//    All flags/counts are registered-state functions, evaluated before the current edge.
//  - Write accepted iff wr_en & !full & !wr_drop: mem[wr_ptr]={wr_last,din}, wr_ptr+1.
//    PKT_MODE=1: accepted word with wr_last sets cmt_ptr=new wr_ptr, pkt_count+1.
//    PKT_MODE=0: cmt_ptr follows wr_ptr every write; wr_drop ignored; pkt_count counts wr_last words.
//  - wr_drop=1 (PKT_MODE=1): wr_ptr<=cmt_ptr; same-cycle wr_en word discarded; no flag set.
//  - wr_en & full: word discarded, overflow<=1. If a packet is open (wr_ptr!=cmt_ptr) it is auto-dropped
//    (wr_ptr<=cmt_ptr), so a packet longer than DEPTH never deadlocks; remaining words until wr_last land
//    as a new (truncated) packet - producer must watch overflow.
//  - Read accepted iff rd_en & !empty: rd_ptr+1. Memory is async-read.
//    FWFT: dout/dout_last = mem[rd_ptr] combinational, valid = !empty; pop on rd_en & valid.
//    STD: dout/dout_last registered from mem[rd_ptr] at accept; valid=1 exactly the next cycle, else 0;
//    dout holds its value otherwise.
//  - rd_en & empty: no pop, underflow<=1.
//  - pkt_count: +1 on commit, -1 on pop of a word with last=1; both same cycle -> unchanged.
//  - Simultaneous write and read are both honoured; read of committed data never blocked by writes.
//  - err_clr clears sticky flags; a new error in the same cycle wins (flag stays 1).
//  - Reset mid-packet: open and committed data both lost; pointers return to 0.
// TESTING  (DATA_WIDTH=8, DEPTH=16, PKT_MODE=1)
//  1 write 4 words 0x10..0x13, last on 0x13 -> rd_data_count 0 during, 4 and pkt_count 1 cycle after last;
//    FWFT reads 0x10..0x13, dout_last=1 on 0x13, then empty=1, pkt_count 0.
//  2 write 3 words, wr_drop on 4th cycle with wr_en -> wr_data_count 0, empty stays 1, overflow 0.
//  3 write 20 words no last -> at 17th write overflow=1, wr_data_count 0; words 18..20 + last form
//    a committed 4-word packet.
//  4 MODE="STD": commit 2 words 0xA0,0xA1; rd_en 3 cycles -> valid 1,1 with 0xA0,0xA1 one cycle after
//    each rd_en; 3rd rd_en sets underflow; err_clr clears it.
//  5 fill 15 committed words -> almost_full at 14, full=0; simultaneous wr+rd at 15 keeps count 15;
//    16th write -> full=1; write at full -> overflow=1, count stays 16.
//  6 rst low mid-packet with 5 committed words -> all outputs at reset values same cycle (async);
//    after release, fresh 2-word packet reads back correctly.

Source files
------------

// File: rtl/sync_pkt_fifo.sv
// Single-clock packet FIFO: words become readable only when their packet commits.
// Supports packet drop, FWFT or registered (STD) read, almost flags, packet count and sticky errors.
module sync_pkt_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter string       MODE       = "FWFT",
    parameter int unsigned PKT_MODE   = 1,
    parameter int unsigned AFULL_TH   = DEPTH - 2,
    parameter int unsigned AEMPTY_TH  = 2
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       wr_last,
    input  logic                       wr_drop,
    input  logic                       rd_en,
    input  logic                       err_clr,
    output logic                       valid,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       dout_last,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     wr_data_count,
    output logic [$clog2(DEPTH):0]     rd_data_count,
    output logic [$clog2(DEPTH):0]     pkt_count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] AF_CNT   = AFULL_TH[AW:0];
    localparam logic [AW:0] AE_CNT   = AEMPTY_TH[AW:0];
    localparam bit          PKT      = (PKT_MODE != 0);
    localparam bit          STD_RD   = (MODE == "STD");

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         cmt_ptr;
    logic [AW:0]         rd_ptr;
    logic [DATA_WIDTH:0] rd_word;
    logic                drop_req;
    logic                wr_acc;
    logic                ovf_evt;
    logic                rewind;
    logic                commit;
    logic                pkt_inc;
    logic                rd_acc;
    logic                unf_evt;
    logic                pop_last;

    always_comb begin
        wr_data_count = wr_ptr - rd_ptr;
        rd_data_count = cmt_ptr - rd_ptr;
        full          = (wr_data_count == FULL_CNT);
        empty         = (cmt_ptr == rd_ptr);
        almost_full   = (wr_data_count >= AF_CNT);
        almost_empty  = (rd_data_count <= AE_CNT);
        rd_word       = mem[rd_ptr[AW-1:0]];

        drop_req = PKT && wr_drop;
        wr_acc   = wr_en && !full && !drop_req;
        ovf_evt  = wr_en && full;
        // Overflow with an open packet rewinds it so an over-long packet cannot wedge the FIFO.
        rewind   = drop_req || (PKT && ovf_evt && (wr_ptr != cmt_ptr));
        commit   = wr_acc && (wr_last || !PKT);
        pkt_inc  = wr_acc && wr_last;
        rd_acc   = rd_en && !empty;
        unf_evt  = rd_en && empty;
        pop_last = rd_acc && rd_word[DATA_WIDTH];
    end

    always_ff @(posedge sys_clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= {wr_last, din};
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            cmt_ptr   <= '0;
            rd_ptr    <= '0;
            pkt_count <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (rewind) begin
                wr_ptr <= cmt_ptr;
            end else if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (commit) begin
                cmt_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({pkt_inc, pop_last})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
            overflow  <= ovf_evt || (overflow && !err_clr);
            underflow <= unf_evt || (underflow && !err_clr);
        end
    end

    if (STD_RD) begin : g_std
        logic                  valid_r;
        logic [DATA_WIDTH-1:0] dout_r;
        logic                  last_r;

        always_ff @(posedge sys_clk or negedge rst) begin
            if (!rst) begin
                valid_r <= 1'b0;
                dout_r  <= '0;
                last_r  <= 1'b0;
            end else begin
                valid_r <= rd_acc;
                if (rd_acc) begin
                    {last_r, dout_r} <= rd_word;
                end
            end
        end

        assign valid     = valid_r;
        assign dout      = dout_r;
        assign dout_last = last_r;
    end else begin : g_fwft
        // Memory is not reset, so the head word is masked while nothing is readable.
        assign valid     = !empty;
        assign dout      = empty ? '0 : rd_word[DATA_WIDTH-1:0];
        assign dout_last = !empty && rd_word[DATA_WIDTH];
    end

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Directed bench for sync_pkt_fifo: FWFT and STD instances share one stimulus stream.
module tb_sync_pkt_fifo;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       wr_en, wr_last, wr_drop, rd_en, err_clr;
    logic [7:0] din;

    logic       f_valid, f_last, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [7:0] f_dout;
    logic [4:0] f_wcnt, f_rcnt, f_pkt;
    logic       s_valid, s_last, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [7:0] s_dout;
    logic [4:0] s_wcnt, s_rcnt, s_pkt;

    int errs = 0;
    int nchk = 0;

    always #5 sys_clk = ~sys_clk;

    sync_pkt_fifo #(.DATA_WIDTH(8), .DEPTH(16), .MODE("FWFT"), .PKT_MODE(1)) u_fwft (
        .sys_clk(sys_clk), .rst(rst), .wr_en(wr_en), .din(din), .wr_last(wr_last),
        .wr_drop(wr_drop), .rd_en(rd_en), .err_clr(err_clr), .valid(f_valid), .dout(f_dout),
        .dout_last(f_last), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .wr_data_count(f_wcnt), .rd_data_count(f_rcnt),
        .pkt_count(f_pkt), .overflow(f_ovf), .underflow(f_unf)
    );

    sync_pkt_fifo #(.DATA_WIDTH(8), .DEPTH(16), .MODE("STD"), .PKT_MODE(1)) u_std (
        .sys_clk(sys_clk), .rst(rst), .wr_en(wr_en), .din(din), .wr_last(wr_last),
        .wr_drop(wr_drop), .rd_en(rd_en), .err_clr(err_clr), .valid(s_valid), .dout(s_dout),
        .dout_last(s_last), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .wr_data_count(s_wcnt), .rd_data_count(s_rcnt),
        .pkt_count(s_pkt), .overflow(s_ovf), .underflow(s_unf)
    );

    typedef struct {
        int we, d, wl, dr, re, ec;
        int valid, dout, last, full, empty, af, ae, wcnt, rcnt, pkt, ovf, unf;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; din = 8'h00; wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic check_f(input string t, input vec_t v);
        chk({t, ".valid"},        int'(f_valid), v.valid);
        chk({t, ".dout"},         int'(f_dout),  v.dout);
        chk({t, ".dout_last"},    int'(f_last),  v.last);
        chk({t, ".full"},         int'(f_full),  v.full);
        chk({t, ".empty"},        int'(f_empty), v.empty);
        chk({t, ".almost_full"},  int'(f_af),    v.af);
        chk({t, ".almost_empty"}, int'(f_ae),    v.ae);
        chk({t, ".wr_data_count"},int'(f_wcnt),  v.wcnt);
        chk({t, ".rd_data_count"},int'(f_rcnt),  v.rcnt);
        chk({t, ".pkt_count"},    int'(f_pkt),   v.pkt);
        chk({t, ".overflow"},     int'(f_ovf),   v.ovf);
        chk({t, ".underflow"},    int'(f_unf),   v.unf);
    endtask

    task automatic check_reset_vals(input string t);
        chk({t, ".f_valid"}, int'(f_valid), 0);
        chk({t, ".f_dout"},  int'(f_dout),  0);
        chk({t, ".f_last"},  int'(f_last),  0);
        chk({t, ".f_full"},  int'(f_full),  0);
        chk({t, ".f_empty"}, int'(f_empty), 1);
        chk({t, ".f_af"},    int'(f_af),    0);
        chk({t, ".f_ae"},    int'(f_ae),    1);
        chk({t, ".f_wcnt"},  int'(f_wcnt),  0);
        chk({t, ".f_rcnt"},  int'(f_rcnt),  0);
        chk({t, ".f_pkt"},   int'(f_pkt),   0);
        chk({t, ".f_ovf"},   int'(f_ovf),   0);
        chk({t, ".f_unf"},   int'(f_unf),   0);
        chk({t, ".s_valid"}, int'(s_valid), 0);
        chk({t, ".s_dout"},  int'(s_dout),  0);
        chk({t, ".s_empty"}, int'(s_empty), 1);
    endtask

    initial begin
        //          we  d     wl dr re ec  val dout  lst ful emp af ae wc rc pk ov un
        vt[0]  = '{1, 'h10, 0, 0, 0, 0,  0, 'h00, 0,  0,  1,  0, 1, 1, 0, 0, 0, 0};
        vt[1]  = '{1, 'h11, 0, 0, 0, 0,  0, 'h00, 0,  0,  1,  0, 1, 2, 0, 0, 0, 0};
        vt[2]  = '{1, 'h12, 0, 0, 0, 0,  0, 'h00, 0,  0,  1,  0, 1, 3, 0, 0, 0, 0};
        vt[3]  = '{1, 'h13, 1, 0, 0, 0,  1, 'h10, 0,  0,  0,  0, 0, 4, 4, 1, 0, 0};
        vt[4]  = '{0, 'h00, 0, 0, 1, 0,  1, 'h11, 0,  0,  0,  0, 0, 3, 3, 1, 0, 0};
        vt[5]  = '{0, 'h00, 0, 0, 1, 0,  1, 'h12, 0,  0,  0,  0, 1, 2, 2, 1, 0, 0};
        vt[6]  = '{0, 'h00, 0, 0, 1, 0,  1, 'h13, 1,  0,  0,  0, 1, 1, 1, 1, 0, 0};
        vt[7]  = '{0, 'h00, 0, 0, 1, 0,  0, 'h00, 0,  0,  1,  0, 1, 0, 0, 0, 0, 0};
        vt[8]  = '{1, 'h20, 0, 0, 0, 0,  0, 'h00, 0,  0,  1,  0, 1, 1, 0, 0, 0, 0};
        vt[9]  = '{1, 'h21, 0, 0, 0, 0,  0, 'h00, 0,  0,  1,  0, 1, 2, 0, 0, 0, 0};
        vt[10] = '{1, 'h22, 0, 0, 0, 0,  0, 'h00, 0,  0,  1,  0, 1, 3, 0, 0, 0, 0};
        vt[11] = '{1, 'h23, 0, 1, 0, 0,  0, 'h00, 0,  0,  1,  0, 1, 0, 0, 0, 0, 0};

        idle();
        rst = 1'b0;
        repeat (2) step();
        check_reset_vals("reset");
        rst = 1'b1;
        step();

        // Packet write/read and drop of an open packet.
        for (int i = 0; i < 12; i++) begin
            wr_en   = vt[i].we[0];
            din     = vt[i].d[7:0];
            wr_last = vt[i].wl[0];
            wr_drop = vt[i].dr[0];
            rd_en   = vt[i].re[0];
            err_clr = vt[i].ec[0];
            step();
            check_f($sformatf("v%0d", i), vt[i]);
        end
        idle();

        // Over-long packet: auto-drop at 17th write, then truncated tail commits.
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1;
            din   = 8'h30 + 8'(i);
            step();
            if (i == 15) begin
                chk("t3.full16", int'(f_full), 1);
                chk("t3.wcnt16", int'(f_wcnt), 16);
            end
            if (i == 16) begin
                chk("t3.ovf17",  int'(f_ovf),  1);
                chk("t3.wcnt17", int'(f_wcnt), 0);
                chk("t3.full17", int'(f_full), 0);
            end
        end
        din = 8'h44; wr_last = 1'b1;
        step();
        idle();
        chk("t3.rcnt", int'(f_rcnt), 4);
        chk("t3.pkt",  int'(f_pkt),  1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3.dout%0d", i), int'(f_dout), 'h41 + i);
            chk($sformatf("t3.last%0d", i), int'(f_last), (i == 3) ? 1 : 0);
            rd_en = 1'b1;
            step();
        end
        idle();
        chk("t3.empty", int'(f_empty), 1);
        chk("t3.pkt0",  int'(f_pkt),   0);
        rd_en = 1'b1; err_clr = 1'b1;
        step();
        chk("t3.ovf_clr",      int'(f_ovf), 0);
        chk("t3.unf_new_wins", int'(f_unf), 1);
        rd_en = 1'b0;
        step();
        chk("t3.unf_clr", int'(f_unf), 0);
        idle();

        // STD read timing and underflow.
        rst = 1'b0;
        step();
        rst = 1'b1;
        wr_en = 1'b1; din = 8'hA0;
        step();
        din = 8'hA1; wr_last = 1'b1;
        step();
        idle();
        chk("t4.valid_pre", int'(s_valid), 0);
        chk("t4.dout_pre",  int'(s_dout),  0);
        rd_en = 1'b1;
        step();
        chk("t4.valid1", int'(s_valid), 1);
        chk("t4.dout1",  int'(s_dout),  'hA0);
        chk("t4.last1",  int'(s_last),  0);
        step();
        chk("t4.valid2", int'(s_valid), 1);
        chk("t4.dout2",  int'(s_dout),  'hA1);
        chk("t4.last2",  int'(s_last),  1);
        chk("t4.unf2",   int'(s_unf),   0);
        step();
        chk("t4.valid3", int'(s_valid), 0);
        chk("t4.dout3",  int'(s_dout),  'hA1);
        chk("t4.unf3",   int'(s_unf),   1);
        rd_en = 1'b0; err_clr = 1'b1;
        step();
        chk("t4.unf_clr", int'(s_unf), 0);
        chk("t4.pkt",     int'(s_pkt), 0);
        idle();

        // Fill toward full with single-word packets.
        for (int i = 0; i < 15; i++) begin
            wr_en = 1'b1; din = 8'(i); wr_last = 1'b1;
            step();
            if (i == 12) chk("t5.af13", int'(f_af), 0);
            if (i == 13) begin
                chk("t5.af14",   int'(f_af),   1);
                chk("t5.full14", int'(f_full), 0);
            end
        end
        chk("t5.wcnt15", int'(f_wcnt), 15);
        rd_en = 1'b1; din = 8'h0F;
        step();
        rd_en = 1'b0;
        chk("t5.wcnt_wrrd", int'(f_wcnt), 15);
        chk("t5.pkt_wrrd",  int'(f_pkt),  15);
        chk("t5.dout_wrrd", int'(f_dout), 'h01);
        din = 8'h10;
        step();
        chk("t5.full16", int'(f_full), 1);
        chk("t5.wcnt16", int'(f_wcnt), 16);
        din = 8'h11;
        step();
        chk("t5.ovf",      int'(f_ovf),  1);
        chk("t5.wcnt_ovf", int'(f_wcnt), 16);
        chk("t5.pkt_ovf",  int'(f_pkt),  16);
        idle();

        // Asynchronous reset mid-packet.
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; din = 8'h70 + 8'(i); wr_last = (i == 4);
            step();
        end
        idle();
        chk("t6.rcnt_pre", int'(f_rcnt), 5);
        chk("t6.wcnt_pre", int'(f_wcnt), 7);
        #1 rst = 1'b0;
        #1;
        check_reset_vals("t6.async");
        rst = 1'b1;
        wr_en = 1'b1; din = 8'h55;
        step();
        din = 8'h66; wr_last = 1'b1;
        step();
        idle();
        chk("t6.pkt",   int'(f_pkt),  1);
        chk("t6.dout0", int'(f_dout), 'h55);
        chk("t6.last0", int'(f_last), 0);
        rd_en = 1'b1;
        step();
        chk("t6.dout1", int'(f_dout), 'h66);
        chk("t6.last1", int'(f_last), 1);
        step();
        idle();
        chk("t6.empty", int'(f_empty), 1);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
